// File: rtl/iq_symbol_mapper_pkg.sv
// Shared types and helpers for the I/Q symbol mapper.
// IQMAP_PREAMBLE_EN adds the PREAMBLE state to state_e.
package iq_mapper_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_16QAM = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Legacy state encodings, kept stable so existing debug probes still decode.
  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_DATA_ENC     = 2'd1;
  localparam logic [1:0] ST_PREAMBLE_ENC = 2'd2;

`ifdef IQMAP_PREAMBLE_EN
  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_DATA     = ST_DATA_ENC,
    ST_PREAMBLE = ST_PREAMBLE_ENC
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_DATA = ST_DATA_ENC
  } state_e;
`endif

  // Payload bits consumed per symbol; reserved mode consumes none.
  function automatic int unsigned bits_per_sym(mode_e m);
    case (m)
      MODE_BPSK:  return 1;
      MODE_QPSK:  return 2;
      MODE_16QAM: return 4;
      default:    return 0;
    endcase
  endfunction

  // Gray-coded 16QAM axis level in units of S = 2^(iq_w-3).
  function automatic int gray_level(logic [1:0] pair, int unsigned iq_w);
    int s;
    s = 1 << (iq_w - 3);
    case (pair)
      2'b00:   return 3 * s;
      2'b01:   return s;
      2'b11:   return -s;
      default: return -3 * s;
    endcase
  endfunction

endpackage

// File: rtl/iq_symbol_mapper_fifo.sv
// Word FIFO for the symbol mapper: {mode, data} entries, first-word
// fall-through read, simultaneous push and pop allowed when full.
module iq_word_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iq_symbol_mapper.sv
// Transmit symbol mapper: buffers words, serialises them into BPSK/QPSK/16QAM
// symbols (mode per word) and holds each I/Q pair for SPS enabled cycles.
// Define IQMAP_PREAMBLE_EN to emit an alternating BPSK preamble on every
// IDLE-to-active transition.
module iq_symbol_mapper #(
  parameter int DATA_W       = 4,
  parameter int IQ_W         = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int SPS          = 1,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  output logic              sym_strobe,
  output logic [IQ_W-1:0]   i_out,
  output logic [IQ_W-1:0]   q_out,
  output logic              mode_err
);

  import iq_mapper_pkg::*;

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int SL_W  = $clog2(DATA_W);
  localparam logic signed [IQ_W-1:0] POS_A = IQ_W'(3 * (1 << (IQ_W - 3)));
  localparam logic signed [IQ_W-1:0] NEG_A = IQ_W'(-3 * (1 << (IQ_W - 3)));

  state_e                   state;
  logic [CNT_W-1:0]         sps_cnt;
  logic                     boundary;
  logic [DATA_W+1:0]        fifo_rd;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  mode_e                    fifo_mode;
  logic [DATA_W-1:0]        cur_data;
  mode_e                    cur_mode;
  logic [SL_W-1:0]          sym_left;
  logic                     load;
  logic                     emit_data;
  mode_e                    src_mode;
  logic [DATA_W-1:0]        src_data;
  logic [3:0]               top4;
  int unsigned              bps;
  logic [SL_W-1:0]          first_left;
  logic signed [IQ_W-1:0]   sym_i;
  logic signed [IQ_W-1:0]   sym_q;

  assign in_ready  = !fifo_full;
  assign boundary  = en && (sps_cnt == '0);
  assign fifo_mode = mode_e'(fifo_rd[DATA_W+1 -: 2]);

  iq_word_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid && in_ready),
    .wr_data ({in_mode, in_data}),
    .rd_en   (load),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

`ifdef IQMAP_PREAMBLE_EN
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  logic [PRE_W-1:0] pre_idx;

  // Preamble symbol index; the IDLE boundary emits symbol 0 itself.
  always_ff @(posedge clk) begin
    if (!rst_n) pre_idx <= '0;
    else if (boundary && state == ST_IDLE) pre_idx <= PRE_W'(1);
    else if (boundary && state == ST_PREAMBLE && !load) pre_idx <= pre_idx + 1'b1;
  end
`else
  // PREAMBLE_LEN has no function without the preamble state.
  logic unused_pre_len;
  assign unused_pre_len = ^PREAMBLE_LEN;
`endif

  // Symbol timing counter, frozen while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) sps_cnt <= '0;
    else if (en) sps_cnt <= (sps_cnt == CNT_W'(SPS - 1)) ? '0 : sps_cnt + 1'b1;
  end

  // Decide at a boundary whether to pop a new word and whether a data symbol is emitted.
  always_comb begin
    load      = 1'b0;
    emit_data = 1'b0;
    if (boundary) begin
      case (state)
        ST_IDLE: begin
`ifndef IQMAP_PREAMBLE_EN
          load = !fifo_empty;
`endif
        end
`ifdef IQMAP_PREAMBLE_EN
        ST_PREAMBLE: load = (pre_idx == PRE_W'(PREAMBLE_LEN));
`endif
        ST_DATA: load = (sym_left == '0) && !fifo_empty;
        default: load = 1'b0;
      endcase
      emit_data = load || (state == ST_DATA && sym_left != '0);
    end
  end

  // Map the leading bits of the current (or freshly popped) word to I/Q.
  always_comb begin
    src_data = load ? fifo_rd[DATA_W-1:0] : cur_data;
    src_mode = load ? fifo_mode : cur_mode;
    top4     = src_data[DATA_W-1 -: 4];
    sym_i    = '0;
    sym_q    = '0;
    case (src_mode)
      MODE_BPSK: sym_i = top4[3] ? NEG_A : POS_A;
      MODE_QPSK: begin
        sym_i = top4[3] ? NEG_A : POS_A;
        sym_q = top4[2] ? NEG_A : POS_A;
      end
      MODE_16QAM: begin
        sym_i = IQ_W'(gray_level(top4[3:2], IQ_W));
        sym_q = IQ_W'(gray_level(top4[1:0], IQ_W));
      end
      default: ;
    endcase
    bps        = bits_per_sym(src_mode);
    first_left = (bps == 0) ? '0 : SL_W'(DATA_W / bps - 1);
  end

  // FSM and registered outputs; everything advances only on a symbol boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_data   <= '0;
      cur_mode   <= MODE_BPSK;
      sym_left   <= '0;
      out_valid  <= 1'b0;
      sym_strobe <= 1'b0;
      i_out      <= '0;
      q_out      <= '0;
      mode_err   <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      if (emit_data) begin
        state      <= ST_DATA;
        sym_strobe <= 1'b1;
        if (src_mode == MODE_RSVD) begin
          // Reserved word occupies one silent symbol slot, then the next word is fetched.
          out_valid <= 1'b0;
          i_out     <= '0;
          q_out     <= '0;
          mode_err  <= 1'b1;
          sym_left  <= '0;
        end else begin
          out_valid <= 1'b1;
          i_out     <= sym_i;
          q_out     <= sym_q;
          cur_data  <= src_data << bps;
          cur_mode  <= src_mode;
          sym_left  <= load ? first_left : sym_left - 1'b1;
        end
      end
`ifdef IQMAP_PREAMBLE_EN
      else if (boundary && state == ST_IDLE && !fifo_empty) begin
        state      <= ST_PREAMBLE;
        sym_strobe <= 1'b1;
        out_valid  <= 1'b1;
        i_out      <= POS_A;
        q_out      <= '0;
      end else if (boundary && state == ST_PREAMBLE) begin
        sym_strobe <= 1'b1;
        out_valid  <= 1'b1;
        i_out      <= pre_idx[0] ? NEG_A : POS_A;
        q_out      <= '0;
      end
`endif
      else if (boundary) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
        i_out     <= '0;
        q_out     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Randomised bench for iq_symbol_mapper: expected symbol stream is built
// from the mapping rules per pushed word and compared at every strobe.
module tb_iq_symbol_mapper;

  localparam int DATA_W     = 8;
  localparam int IQ_W       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int SPS        = 3;
  localparam int PRE_LEN    = 4;
  localparam int S          = 1 << (IQ_W - 3);
  localparam int A          = 3 * S;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              sym_strobe;
  logic [IQ_W-1:0]   i_out;
  logic [IQ_W-1:0]   q_out;
  logic              mode_err;

  iq_symbol_mapper #(
    .DATA_W       (DATA_W),
    .IQ_W         (IQ_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .SPS          (SPS),
    .PREAMBLE_LEN (PRE_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .sym_strobe (sym_strobe),
    .i_out      (i_out),
    .q_out      (q_out),
    .mode_err   (mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int i;
    int q;
  } sym_t;

  sym_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   en_mode  = 0;
  bit   mon_on   = 1'b0;
  bit   saw_rsvd = 1'b0;
  bit   last_v;
  int   last_i;
  int   last_q;
  bit   open_sym;
  int   en_cnt;

  task automatic check_val(string tag, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int axis_level(int pair);
    case (pair)
      0:       return 3 * S;
      1:       return S;
      3:       return -S;
      default: return -3 * S;
    endcase
  endfunction

  task automatic expect_word(logic [DATA_W-1:0] w, int m);
    int   bps;
    int   bits;
    sym_t s;
    if (m == 3) begin
      s = '{1'b0, 0, 0};
      exp_q.push_back(s);
      saw_rsvd = 1'b1;
      return;
    end
    bps = (m == 0) ? 1 : (m == 1) ? 2 : 4;
    for (int k = 0; k < DATA_W / bps; k++) begin
      bits = (int'(w) >> (DATA_W - bps * (k + 1))) & ((1 << bps) - 1);
      case (m)
        0:       s = '{1'b1, (bits != 0) ? -A : A, 0};
        1:       s = '{1'b1, ((bits >> 1) != 0) ? -A : A, ((bits & 1) != 0) ? -A : A};
        default: s = '{1'b1, axis_level(bits >> 2), axis_level(bits & 3)};
      endcase
      exp_q.push_back(s);
    end
  endtask

  task automatic expect_preamble();
`ifdef IQMAP_PREAMBLE_EN
    sym_t s;
    for (int k = 0; k < PRE_LEN; k++) begin
      s = '{1'b1, (k % 2 != 0) ? -A : A, 0};
      exp_q.push_back(s);
    end
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic push_word(logic [DATA_W-1:0] w, int m);
    int waited = 0;
    while (!in_ready && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    check_val("push_ready", int'(in_ready), 1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_data  = w;
    in_mode  = 2'(m);
    expect_word(w, m);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 5000) begin
      @(posedge clk); #1;
      waited++;
    end
    check_val("drain_done", exp_q.size(), 0);
    exp_q.delete();
    en_mode = 2;
    repeat (2 * SPS + 3) @(posedge clk);
    #1;
    check_val("drain_idle", int'(out_valid), 0);
    check_val("drain_ready", int'(in_ready), 1);
    en_mode = 1;
  endtask

  initial begin
    en = 1'b0;
    forever begin
      @(posedge clk); #1;
      en = (en_mode == 0) ? 1'b0 : (en_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    int   ci;
    int   cq;
    sym_t e;
    if (mon_on) begin
      ci = $signed(i_out);
      cq = $signed(q_out);
      if (sym_strobe) begin
        if (open_sym) check_val("hold_len", en_cnt, SPS);
        if (exp_q.size() == 0) check_val("unexpected_sym", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_val("sym_valid", int'(out_valid), int'(e.v));
          check_val("sym_i", ci, e.i);
          check_val("sym_q", cq, e.q);
        end
        open_sym = 1'b1;
        en_cnt   = int'(en);
      end else if (out_valid != last_v || ci != last_i || cq != last_q) begin
        if (open_sym) check_val("hold_len_end", en_cnt, SPS);
        check_val("idle_valid", int'(out_valid), 0);
        check_val("idle_i", ci, 0);
        check_val("idle_q", cq, 0);
        check_val("idle_pending", exp_q.size(), 0);
        open_sym = 1'b0;
      end else if (open_sym) begin
        en_cnt += int'(en);
        if (exp_q.size() == 0 && en_cnt > SPS) open_sym = 1'b0;
      end
      last_v = out_valid;
      last_i = ci;
      last_q = cq;
    end
  end

  initial begin
    int n;
    int r;
    int m;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = '0;
    en_mode  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", int'(in_ready), 1);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_strobe", int'(sym_strobe), 0);
    check_val("rst_i", int'(i_out), 0);
    check_val("rst_q", int'(q_out), 0);
    check_val("rst_mode_err", int'(mode_err), 0);

    rst_n    = 1'b1;
    last_v   = 1'b0;
    last_i   = 0;
    last_q   = 0;
    open_sym = 1'b0;
    en_cnt   = 0;
    mon_on   = 1'b1;

    // Backpressure: with en low nothing is consumed, so the FIFO fills after FIFO_DEPTH words.
    expect_preamble();
    for (int k = 0; k < FIFO_DEPTH; k++) push_word(DATA_W'($urandom), 0);
    check_val("full_ready", int'(in_ready), 0);
    en_mode = 1;
    for (int k = 0; k < 2; k++) push_word(DATA_W'($urandom), 0);
    drain();
    check_val("mode_err_clear", int'(mode_err), int'(saw_rsvd));

    for (int b = 0; b < 14; b++) begin
      expect_preamble();
      n = $urandom_range(1, FIFO_DEPTH);
      for (int w = 0; w < n; w++) begin
        r = $urandom_range(0, 6);
        m = (r == 6) ? 3 : r % 3;
        if (b == 3 && w == 0) m = 3;
        push_word(DATA_W'($urandom), m);
      end
      drain();
    end
    check_val("mode_err_sticky", int'(mode_err), int'(saw_rsvd));

    mon_on = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    check_val("rerst_mode_err", int'(mode_err), 0);
    check_val("rerst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
